// File: rtl/cmp_pkg.sv
// cmp_pkg: shared data width, tracker state type and saturating increment.
package cmp_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, ACCEPT, CMP_MAX, CMP_MIN, DONE} mm_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    return (v == ((32'd1 << w) - 32'd1)) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame max/min/count/max-tie statistics using an external comparator.
module minmax_tracker
  import cmp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic              cmp_gt,
  input  logic              cmp_eq,
  input  logic              cmp_lt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  out_max_ties
);
  mm_state_t state, next;
  logic [DATA_W-1:0] max_r, min_r, samp, new_min;
  logic [CNT_W-1:0] count, ties;
  logic last, xfer;
  assign in_ready = !rst && (state == IDLE || state == ACCEPT);
  assign xfer = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign new_min = cmp_lt ? samp : min_r;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = xfer ? (in_last ? DONE : ACCEPT) : IDLE;
      ACCEPT:  next = xfer ? CMP_MAX : ACCEPT;
      CMP_MAX: next = CMP_MIN;
      CMP_MIN: next = last ? DONE : ACCEPT;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      max_r <= '0;
      min_r <= '0;
      samp <= '0;
      count <= '0;
      ties <= '0;
      last <= 1'b0;
      cmp_a <= '0;
      cmp_b <= '0;
      out_max <= '0;
      out_min <= '0;
      out_count <= '0;
      out_max_ties <= '0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          max_r <= in_data;
          min_r <= in_data;
          samp <= in_data;
          count <= CNT_W'(1);
          ties <= CNT_W'(1);
          last <= in_last;
          if (in_last) begin
            out_max <= in_data;
            out_min <= in_data;
            out_count <= CNT_W'(1);
            out_max_ties <= CNT_W'(1);
          end
        end
        ACCEPT: if (xfer) begin
          samp <= in_data;
          count <= CNT_W'(sat_inc(32'(count), CNT_W));
          last <= in_last;
          cmp_a <= in_data;
          cmp_b <= max_r;
        end
        CMP_MAX: begin
          if (cmp_gt) begin
            max_r <= samp;
            ties <= CNT_W'(1);
          end else if (cmp_eq) ties <= CNT_W'(sat_inc(32'(ties), CNT_W));
          cmp_b <= min_r;
        end
        CMP_MIN: begin
          min_r <= new_min;
          // max_r already reflects this sample's CMP_MAX outcome
          if (last) begin
            out_max <= max_r;
            out_min <= new_min;
            out_count <= count;
            out_max_ties <= ties;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: directed frames against a cascaded comparator, scoreboarded results.
module tb_minmax_tracker;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, in_ready;
  logic [7:0] in_data = 0, cmp_a, cmp_b, out_max, out_min;
  logic cmp_gt, cmp_eq, cmp_lt, out_valid, out_ready = 1;
  logic [7:0] out_count, out_max_ties;
  int n_cmp = 0, n_bad = 0;
  typedef struct { logic [7:0] mx, mn, cnt, ties; } res_t;
  res_t sb[$];

  always #5 clk = ~clk;

  minmax_tracker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_eq(cmp_eq),
    .cmp_lt(cmp_lt), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_min(out_min), .out_count(out_count), .out_max_ties(out_max_ties)
  );

  // 8-bit cascaded comparator, cascade inputs g=0 e=1 l=0
  always_comb begin
    cmp_gt = 1'b0;
    cmp_eq = 1'b1;
    cmp_lt = 1'b0;
    for (int i = 7; i >= 0; i--)
      if (cmp_eq && cmp_a[i] != cmp_b[i]) begin
        cmp_gt = cmp_a[i];
        cmp_lt = cmp_b[i];
        cmp_eq = 1'b0;
      end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [7:0] d[$]);
    res_t r;
    r.mx = d[0]; r.mn = d[0]; r.cnt = 1; r.ties = 1;
    for (int i = 1; i < d.size(); i++) begin
      if (r.cnt != 8'hFF) r.cnt++;
      if (d[i] > r.mx) begin r.mx = d[i]; r.ties = 1; end
      else if (d[i] == r.mx && r.ties != 8'hFF) r.ties++;
      if (d[i] < r.mn) r.mn = d[i];
    end
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input logic l);
    int t;
    in_valid = 1; in_data = d; in_last = l;
    for (t = 0; t < 50 && !in_ready; t++) @(negedge clk);
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] d[$]);
    sb.push_back(model(d));
    for (int i = 0; i < d.size(); i++) send(d[i], i == d.size() - 1);
  endtask

  initial begin : monitor
    logic pv = 0;
    res_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !pv) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = sb.pop_front();
          chk("max", out_max, e.mx);
          chk("min", out_min, e.mn);
          chk("count", out_count, e.cnt);
          chk("ties", out_max_ties, e.ties);
        end
      end
      pv = out_valid;
    end
  end

  initial begin
    logic [7:0] q[$];
    int t;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_cmp_b", cmp_b, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    q = '{8'd5, 8'd200, 8'd17, 8'd200, 8'd3};
    send_frame(q);
    chk("lat_a", out_valid, 0);
    @(negedge clk);
    chk("lat_b", out_valid, 0);
    @(negedge clk);
    chk("lat_c", out_valid, 1);
    @(negedge clk);

    q = '{8'h80};
    send_frame(q);
    chk("single_lat", out_valid, 1);
    @(negedge clk);

    sb.push_back(model('{8'h00, 8'hFF, 8'hFF, 8'h00}));
    send(8'h00, 0);
    send(8'hFF, 0);
    chk("cmpmax_a", cmp_a, 8'hFF);
    chk("cmpmax_b", cmp_b, 8'h00);
    chk("cmpmax_gt", cmp_gt, 1);
    send(8'hFF, 0);
    send(8'h00, 1);
    repeat (3) @(negedge clk);

    q = {};
    for (int i = 0; i < 300; i++) q.push_back(8'd9);
    send_frame(q);
    repeat (3) @(negedge clk);

    out_ready = 0;
    q = '{8'd10, 8'd20};
    send_frame(q);
    for (t = 0; t < 10 && !out_valid; t++) @(negedge clk);
    chk("hold_reach_done", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_max", out_max, 20);
      chk("hold_min", out_min, 10);
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);

    send(8'd1, 0);
    send(8'd2, 0);
    send(8'd3, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cmp_a", cmp_a, 0);
    chk("midrst_out_max", out_max, 0);
    rst = 0;
    @(negedge clk);
    chk("midrst_idle", in_ready, 1);
    q = '{8'd4, 8'd7};
    send_frame(q);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/minmax_tracker.md
# minmax_tracker

- Sequential frame statistics engine.
- Consumes a stream of 8-bit samples and reports per frame: maximum, minimum, sample count, and how many samples equalled the maximum.
- Does no magnitude comparison itself. It drives operands into the external 8-bit cascaded comparator (`a0..a7`, `b0..b7`, `g=0`, `e=1`, `l=0`) and consumes that comparator's `gt`/`eq`/`lt` in the same cycle.
- Sits between the sample source and the result register file.

## Interface
Parameters:
- `CNT_W`, default 8: width of the sample and tie counters; both saturate at 2^CNT_W-1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: sample offered.
- `in_data` in 8: sample value, unsigned.
- `in_last` in 1: the offered sample ends the frame.
- `in_ready` out 1: the tracker accepts the sample this cycle.
- `cmp_a` out 8: operand A to the comparator (bit i drives `a<i>`).
- `cmp_b` out 8: operand B to the comparator (bit i drives `b<i>`).
- `cmp_gt` in 1: comparator result, A>B.
- `cmp_eq` in 1: comparator result, A==B.
- `cmp_lt` in 1: comparator result, A<B.
- `out_valid` out 1: frame result available.
- `out_ready` in 1: consumer takes the result.
- `out_max` out 8: frame maximum.
- `out_min` out 8: frame minimum.
- `out_count` out CNT_W: number of samples in the frame (saturating).
- `out_max_ties` out CNT_W: number of samples equal to `out_max` (saturating).

## Operation
States:
- `IDLE`: no frame open.
- `ACCEPT`: frame open, waiting for the next sample.
- `CMP_MAX`, `CMP_MIN`: compare phases.
- `DONE`: result held.

Handshake:
- Transfer occurs when `in_valid && in_ready`.
- `in_ready` = 1 only in `IDLE` and `ACCEPT`.

Transitions:
- `IDLE` + transfer:
  - max, min, and `samp` load `in_data`; count=1; ties=1.
  - If `in_last`, go to `DONE`; otherwise go to `ACCEPT`.
  - No compare is performed for the first sample.
- `ACCEPT` + transfer:
  - `samp`←`in_data`; count+=1 (saturating).
  - Record the `in_last` flag; go to `CMP_MAX`.
- `CMP_MAX`:
  - `cmp_a`=`samp`, `cmp_b`=max.
  - If `cmp_gt`: max←`samp`, ties←1.
  - Else if `cmp_eq`: ties+=1 (saturating).
  - Go to `CMP_MIN`.
- `CMP_MIN`:
  - `cmp_a`=`samp`, `cmp_b`=min.
  - If `cmp_lt`: min←`samp`.
  - Go to `DONE` if the last flag is set; otherwise go to `ACCEPT`.
- `DONE`:
  - `out_valid`=1; outputs are stable.
  - On `out_ready` go to `IDLE`.

Comparator outputs:
- In `IDLE`, `ACCEPT` and `DONE`, `cmp_a`/`cmp_b` hold their last values.
- Only `cmp_gt` decides max and only `cmp_lt` decides min.
- `cmp_eq` counts only when `cmp_gt`=0.
- A non-one-hot comparator response is therefore resolved as gt > eq, with lt evaluated independently.

Saturation:
- count and ties stick at 2^CNT_W-1.
- The frame itself is unaffected.

Reset:
- All state is cleared; the FSM goes to `IDLE`.
- Output reset values: `in_ready`=0 during reset then 1; `out_valid`=0; `out_max`=`out_min`=0; `out_count`=`out_max_ties`=0; `cmp_a`=`cmp_b`=0.
- A reset asserted mid-frame or in `DONE` discards the frame with no output.

## Timing
- Comparator path: purely combinational, from the `cmp_a`/`cmp_b` registers through the comparator to `cmp_*`, sampled in the same cycle.
- Throughput:
  - First sample of a frame: 1 cycle.
  - Each later sample: 3 cycles (`ACCEPT`→`CMP_MAX`→`CMP_MIN`).
- Result latency:
  - A single-sample frame accepted at edge N gives `out_valid` high after edge N.
  - Otherwise `out_valid` rises 2 cycles after the edge that accepts the last sample.
- `out_*` are registers:
  - Updated only on the entry to `DONE`.
  - Held through `DONE` until the `out_ready` handshake.
  - Hold their value after `DONE` exits until the next frame completes.
- `in_valid` asserted during compare phases or `DONE` is ignored; the source must hold the sample.
- `out_ready` outside `DONE` has no effect.

## Structure
- Shared package `cmp_pkg` holds:
  - `DATA_W=8`.
  - The state typedef `mm_state_t` (`IDLE`, `ACCEPT`, `CMP_MAX`, `CMP_MIN`, `DONE`).
  - The saturating-increment function used by both counters.
- Single module; no sub-module.
- The comparator is instantiated alongside the tracker at the next level up, not inside it.
- The testbench instantiates the real 8-bit comparator as the `cmp_*` partner.

## Test plan
- Frame 5, 200, 17, 200, 3 (last on 3) → `out_max`=200, `out_min`=3, `out_count`=5, `out_max_ties`=2; `out_valid` 2 cycles after the last transfer.
- Single-sample frame 0x80 with `in_last`=1 → `out_valid` the next cycle; max=min=0x80, count=1, ties=1.
- Frame 0x00, 0xFF, 0xFF, 0x00 → max=255, ties=2, min=0; `cmp_a`/`cmp_b` observed 0xFF/0x00 in the first `CMP_MAX`.
- 300 samples of value 9 with CNT_W=8 → count=255, ties=255, max=min=9.
- `out_ready` held low 10 cycles in `DONE` → `in_ready`=0 and outputs stable; `out_ready`=1 → `IDLE` next cycle and `in_ready`=1.
- `rst` in `CMP_MIN` of a 3-sample frame → next cycle `out_valid`=0, `cmp_a`=0, `IDLE`; a new frame 4, 7 → max=7, min=4, count=2.
